cache_control: RTL and testbench
================================

# cache_control

Sequencing controller for the two-way, 8-set, 16-byte-line L1 cache built from two `way` datapath instances. It owns the per-set LRU state and runs the hit/miss/write-back/allocate state machine. It drives each way's load, mux and victim-select controls, the CPU `mem_resp` handshake, and the physical-memory `pmem_read`/`pmem_write` handshake. It sits between the CPU memory port and the physical-memory port, beside the cache datapath.

## Interface
Parameters:
- `SETS`, 8: number of sets; LRU array depth. Must match the datapath.
- `SET_W`, 3: set index width, log2(`SETS`).

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: CPU read request, held until `mem_resp`.
- `mem_write` in 1: CPU write request, held until `mem_resp`.
- `set` in `SET_W`: set index of the current CPU address.
- `hit0`, `hit1` in 1: valid-and-tag-match from way 0 and way 1.
- `dirty0`, `dirty1` in 1: LRU-gated dirty status from way 0 and way 1.
- `pmem_resp` in 1: physical memory has completed the current line transfer.
- `mem_resp` out 1: one-cycle CPU completion strobe.
- `pmem_read`, `pmem_write` out 1: physical-memory line read / line write request.
- `pmem_addr_sel` out 1: address source. 0 = CPU address with offset zeroed; 1 = victim way's stored address.
- `lru_in0`, `lru_in1` out 1: victim select to each way, one-hot.
- `write_back` out 1: refill load enable; the datapath gates it per way with `lru_inN`.
- `writemux_sel` out 1: way write source. 0 = refill path; 1 = hit-and-write path.
- `datamux_sel` out 1: line data source. 0 = `pmem_rdata`; 1 = word-inserted line.
- `way_sel` out 1: CPU read-data mux select; 1 = way 1.
- `hit_count`, `miss_count` out 16: present only with `CACHE_PERF_CNT_EN`.

## Operation
- LRU array: `SETS` × 1 bit. The value is the victim way for that set; 0 = way 0.
- `lru_in0 = ~lru[set]` and `lru_in1 = lru[set]`. Both are combinational from the current `set`.
- States: IDLE, HIT_CHECK, WRITE_BACK, ALLOCATE.
- IDLE
  - All strobes are 0.
  - `mem_read | mem_write` → HIT_CHECK.
- HIT_CHECK
  - Request deasserted: → IDLE; no response, no state update.
  - Hit (`hit0 | hit1`):
    - `mem_resp` = 1 and `way_sel = ~hit0 & hit1`; way 0 wins if both hit.
    - `lru[set]` ← the way that did not hit.
    - If `mem_write`: `writemux_sel` = 1 and `datamux_sel` = 1, so the hitting way merges the word and sets dirty.
    - → IDLE.
  - Miss, victim dirty (`dirty0 | dirty1`): → WRITE_BACK.
  - Miss, victim clean: → ALLOCATE.
- WRITE_BACK
  - `pmem_write` = 1 and `pmem_addr_sel` = 1, held until `pmem_resp`.
  - On `pmem_resp`: → ALLOCATE.
- ALLOCATE
  - `pmem_read` = 1, `pmem_addr_sel` = 0, `writemux_sel` = 0, `datamux_sel` = 0.
  - `write_back = pmem_resp`: the victim loads the line, valid, tag and dirty = `mem_write`.
  - On `pmem_resp`: → HIT_CHECK, which re-evaluates and now hits.
- Once WRITE_BACK or ALLOCATE is entered, the memory transaction runs to completion even if the CPU request drops. The return to HIT_CHECK then takes the no-request exit.
- `mem_read` and `mem_write` asserted together: treated as a write.
- `set` must stay stable from request through `mem_resp`. The LRU victim is sampled combinationally in every state, so `set` must not change mid-miss.

## Timing
- Reset (asynchronous, while `reset_n` = 0):
  - State ← IDLE; every `lru` entry ← 0.
  - Outputs: `lru_in0` = 1, `lru_in1` = 0. All other outputs 0. Counters 0.
- Hit: request seen in IDLE at cycle t; `mem_resp` in cycle t+1. Next request is accepted from t+2.
- Clean miss:
  - ALLOCATE entered at t+2.
  - `pmem_resp` at cycle k gives `write_back` = 1 in cycle k.
  - `mem_resp` at k+1.
- Dirty miss: WRITE_BACK from t+2 until `pmem_resp` at cycle j. ALLOCATE from j+1. Then as a clean miss.
- `pmem_read` and `pmem_write` are never high in the same cycle. They drop in the cycle after `pmem_resp`.
- `mem_resp` is exactly one cycle per completed request.

## Configuration
- `CACHE_PERF_CNT_EN` defined:
  - `hit_count` increments on a HIT_CHECK hit that was entered directly from IDLE.
  - `miss_count` increments on every HIT_CHECK → WRITE_BACK or → ALLOCATE transition.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Not defined: both ports and both counters are absent. There is no other behavioural difference.

## Test plan
- Reset, then read set 3 on cold cache → ALLOCATE, `pmem_read` = 1, `lru_in0` = 1. `pmem_resp` after 5 cycles → `write_back` = 1 for one cycle, `mem_resp` next cycle, `lru[3]` = 1.
- Repeat read of same address with `hit0` = 1 → `mem_resp` at t+1, `way_sel` = 0, `pmem_read` and `pmem_write` stay 0.
- Write hit on way 1 → `writemux_sel` = 1, `datamux_sel` = 1, `way_sel` = 1 in the response cycle; `lru[set]` becomes 0.
- Miss with `dirty1` = 1 and `lru[set]` = 1 → `pmem_write` with `pmem_addr_sel` = 1 until `pmem_resp`, then `pmem_read` with `pmem_addr_sel` = 0, then `mem_resp`.
- Drop `mem_read` during ALLOCATE → transfer completes, no `mem_resp`, state returns to IDLE. Assert `reset_n` = 0 mid-WRITE_BACK → `pmem_write` = 0 immediately, state IDLE.
- With `CACHE_PERF_CNT_EN`: 3 hits and 2 misses → `hit_count` = 3, `miss_count` = 2. The post-refill hit is not counted.

Source files
------------

// File: rtl/cache_control.sv
// Sequencing controller for a two-way, 8-set L1 cache: per-set LRU plus the
// hit / write-back / allocate FSM. Optional perf counters via CACHE_PERF_CNT_EN.
module cache_control #(
  parameter int SETS  = 8,
  parameter int SET_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [SET_W-1:0] set,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             dirty0,
  input  logic             dirty1,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic             lru_in0,
  output logic             lru_in1,
  output logic             write_back,
  output logic             writemux_sel,
  output logic             datamux_sel,
  output logic             way_sel,
`ifdef CACHE_PERF_CNT_EN
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count,
`endif
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HIT_CHECK  = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [SETS-1:0] lru;
  logic            lru_we;
  logic            lru_val;
  logic            req;
  logic            hit;

  assign req       = mem_read | mem_write;
  assign hit       = hit0 | hit1;
  assign fsm_state = state;

  // Victim select is purely combinational from the current set index.
  assign lru_in0 = ~lru[set];
  assign lru_in1 =  lru[set];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lru   <= '0;
    end else begin
      state <= state_next;
      if (lru_we) lru[set] <= lru_val;
    end
  end

  // Handshakes: CPU holds mem_read/mem_write until a one-cycle mem_resp;
  // pmem_read/pmem_write stay high until the cycle pmem_resp is seen.
  always_comb begin
    state_next    = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    write_back    = 1'b0;
    writemux_sel  = 1'b0;
    datamux_sel   = 1'b0;
    way_sel       = 1'b0;
    lru_we        = 1'b0;
    lru_val       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) state_next = HIT_CHECK;
      end
      HIT_CHECK: begin
        if (!req) begin
          state_next = IDLE;
        end else if (hit) begin
          mem_resp   = 1'b1;
          way_sel    = ~hit0 & hit1;
          lru_we     = 1'b1;
          lru_val    = hit0;  // the way that did not hit becomes the victim
          if (mem_write) begin
            writemux_sel = 1'b1;
            datamux_sel  = 1'b1;
          end
          state_next = IDLE;
        end else if (dirty0 | dirty1) begin
          state_next = WRITE_BACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read  = 1'b1;
        write_back = pmem_resp;
        if (pmem_resp) state_next = HIT_CHECK;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic from_idle;
  logic count_hit;
  logic count_miss;

  // Only first-look hits count; the re-check after a refill is not a hit.
  assign count_hit  = (state == HIT_CHECK) && req && hit && from_idle;
  assign count_miss = (state == HIT_CHECK) && req && !hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      from_idle  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      from_idle <= (state == IDLE);
      if (count_hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
      if (count_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: cold miss, hits, dirty miss, dropped
// request during refill, and reset during write-back.
module tb_cache_control;

  logic        clk;
  logic        reset_n;
  logic        mem_read, mem_write;
  logic [2:0]  set;
  logic        hit0, hit1, dirty0, dirty1;
  logic        pmem_resp;
  logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic        lru_in0, lru_in1, write_back, writemux_sel, datamux_sel, way_sel;
  logic [1:0]  fsm_state;
`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HC   = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_AL   = 2'd3;

  cache_control #(.SETS(8), .SET_W(3)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .set(set),
    .hit0(hit0),
    .hit1(hit1),
    .dirty0(dirty0),
    .dirty1(dirty1),
    .pmem_resp(pmem_resp),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel),
    .lru_in0(lru_in0),
    .lru_in1(lru_in1),
    .write_back(write_back),
    .writemux_sel(writemux_sel),
    .datamux_sel(datamux_sel),
    .way_sel(way_sel),
`ifdef CACHE_PERF_CNT_EN
    .hit_count(hit_count),
    .miss_count(miss_count),
`endif
    .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed afterwards, away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    set       = 3'd0;
    hit0      = 1'b0;
    hit1      = 1'b0;
    dirty0    = 1'b0;
    dirty1    = 1'b0;
    pmem_resp = 1'b0;
    #12;
    chk("rst_state", fsm_state, S_IDLE);
    chk("rst_lru_in0", lru_in0, 1'b1);
    chk("rst_lru_in1", lru_in1, 1'b0);
    chk("rst_strobes", {mem_resp, pmem_read, pmem_write, pmem_addr_sel, write_back,
                        writemux_sel, datamux_sel, way_sel}, 8'h00);
`ifdef CACHE_PERF_CNT_EN
    chk("rst_hit_count", hit_count, 16'd0);
    chk("rst_miss_count", miss_count, 16'd0);
`endif
    reset_n = 1'b1;
    tick();

    // Cold read miss on set 3.
    set = 3'd3; mem_read = 1'b1; settle();
    chk("cold_idle_resp", mem_resp, 1'b0);
    tick();
    chk("cold_hc_state", fsm_state, S_HC);
    chk("cold_hc_resp", mem_resp, 1'b0);
    tick();
    chk("cold_al_state", fsm_state, S_AL);
    chk("cold_al_pread", pmem_read, 1'b1);
    chk("cold_al_lru_in0", lru_in0, 1'b1);
    chk("cold_al_addr_sel", pmem_addr_sel, 1'b0);
    chk("cold_al_wb_idle", write_back, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cold_al_hold", {pmem_read, pmem_write, write_back}, 3'b100);
    end
    pmem_resp = 1'b1; settle();
    chk("cold_al_write_back", write_back, 1'b1);
    tick();
    pmem_resp = 1'b0; hit0 = 1'b1; settle();
    chk("cold_refill_resp", mem_resp, 1'b1);
    chk("cold_refill_way_sel", way_sel, 1'b0);
    chk("cold_refill_pread", pmem_read, 1'b0);
    chk("cold_refill_wb", write_back, 1'b0);
    tick();
    mem_read = 1'b0; hit0 = 1'b0; settle();
    chk("cold_done_state", fsm_state, S_IDLE);
    chk("cold_done_resp", mem_resp, 1'b0);
    chk("cold_lru3_in1", lru_in1, 1'b1);
    chk("cold_lru3_in0", lru_in0, 1'b0);

    // Read hit on way 0, set 3.
    mem_read = 1'b1; hit0 = 1'b1; settle();
    tick();
    chk("rd_hit_resp", mem_resp, 1'b1);
    chk("rd_hit_way_sel", way_sel, 1'b0);
    chk("rd_hit_pmem", {pmem_read, pmem_write}, 2'b00);
    chk("rd_hit_mux", {writemux_sel, datamux_sel}, 2'b00);
    tick();
    mem_read = 1'b0; hit0 = 1'b0; settle();
    chk("rd_hit_idle", fsm_state, S_IDLE);
    chk("rd_hit_resp_once", mem_resp, 1'b0);
    chk("rd_hit_lru", lru_in1, 1'b1);

    // Write hit on way 1, set 3: LRU flips to way 0.
    mem_write = 1'b1; hit1 = 1'b1; settle();
    tick();
    chk("wr_hit_resp", mem_resp, 1'b1);
    chk("wr_hit_mux", {writemux_sel, datamux_sel}, 2'b11);
    chk("wr_hit_way_sel", way_sel, 1'b1);
    tick();
    mem_write = 1'b0; hit1 = 1'b0; settle();
    chk("wr_hit_lru_in0", lru_in0, 1'b1);
    chk("wr_hit_lru_in1", lru_in1, 1'b0);

    // Both ways hit on a read+write request: way 0 wins, treated as a write.
    mem_read = 1'b1; mem_write = 1'b1; hit0 = 1'b1; hit1 = 1'b1; settle();
    tick();
    chk("both_hit_resp", mem_resp, 1'b1);
    chk("both_hit_way_sel", way_sel, 1'b0);
    chk("both_hit_mux", {writemux_sel, datamux_sel}, 2'b11);
    tick();
    mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0; settle();
    chk("both_hit_lru", lru_in1, 1'b1);

`ifdef CACHE_PERF_CNT_EN
    chk("perf_hits_a", hit_count, 16'd3);
    chk("perf_miss_a", miss_count, 16'd1);
`endif

    // Dirty miss on set 3 with victim way 1.
    mem_read = 1'b1; dirty1 = 1'b1; settle();
    tick();
    chk("dm_hc_state", fsm_state, S_HC);
    tick();
    chk("dm_wb_state", fsm_state, S_WB);
    chk("dm_wb_pmem", {pmem_write, pmem_read, pmem_addr_sel}, 3'b101);
    chk("dm_wb_lru_in1", lru_in1, 1'b1);
    tick();
    tick();
    chk("dm_wb_hold", {pmem_write, pmem_read, pmem_addr_sel}, 3'b101);
    pmem_resp = 1'b1; settle();
    chk("dm_wb_resp_cycle", {pmem_write, write_back}, 2'b10);
    tick();
    pmem_resp = 1'b0; dirty1 = 1'b0; settle();
    chk("dm_al_state", fsm_state, S_AL);
    chk("dm_al_pmem", {pmem_write, pmem_read, pmem_addr_sel}, 3'b010);
    chk("dm_al_mux", {writemux_sel, datamux_sel}, 2'b00);
    tick();
    pmem_resp = 1'b1; settle();
    chk("dm_al_write_back", write_back, 1'b1);
    tick();
    pmem_resp = 1'b0; hit1 = 1'b1; settle();
    chk("dm_resp", mem_resp, 1'b1);
    chk("dm_way_sel", way_sel, 1'b1);
    chk("dm_pmem_drop", {pmem_read, pmem_write}, 2'b00);
    tick();
    mem_read = 1'b0; hit1 = 1'b0; settle();
    chk("dm_lru", lru_in0, 1'b1);

`ifdef CACHE_PERF_CNT_EN
    chk("perf_hits_b", hit_count, 16'd3);
    chk("perf_miss_b", miss_count, 16'd2);
`endif

    // Request dropped during ALLOCATE on set 5.
    set = 3'd5; mem_read = 1'b1; settle();
    tick();
    tick();
    mem_read = 1'b0; settle();
    chk("drop_al_pread", pmem_read, 1'b1);
    tick();
    chk("drop_al_hold", pmem_read, 1'b1);
    pmem_resp = 1'b1; settle();
    chk("drop_al_write_back", write_back, 1'b1);
    tick();
    pmem_resp = 1'b0; settle();
    chk("drop_hc_state", fsm_state, S_HC);
    chk("drop_hc_resp", mem_resp, 1'b0);
    tick();
    chk("drop_idle_state", fsm_state, S_IDLE);
    chk("drop_idle_resp", mem_resp, 1'b0);
    chk("drop_lru5", lru_in0, 1'b1);

    // Set 3 LRU untouched by the set 5 traffic.
    set = 3'd3; settle();
    chk("set3_lru_kept", lru_in0, 1'b1);

`ifdef CACHE_PERF_CNT_EN
    chk("perf_hits_c", hit_count, 16'd3);
    chk("perf_miss_c", miss_count, 16'd3);
`endif

    // Reset asserted mid write-back on set 6.
    set = 3'd6; mem_read = 1'b1; dirty0 = 1'b1; settle();
    tick();
    tick();
    chk("rwb_pwrite", pmem_write, 1'b1);
    #2;
    reset_n = 1'b0; settle();
    chk("rwb_pwrite_drop", pmem_write, 1'b0);
    chk("rwb_state", fsm_state, S_IDLE);
    set = 3'd3; settle();
    chk("rwb_lru_cleared", lru_in0, 1'b1);
`ifdef CACHE_PERF_CNT_EN
    chk("rwb_hit_count", hit_count, 16'd0);
    chk("rwb_miss_count", miss_count, 16'd0);
`endif
    mem_read = 1'b0; dirty0 = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", fsm_state, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
